comp_sort_ctrl: RTL



---
 rtl/comp_sort_ctrl_pkg.sv | 34 +++
 rtl/comp_sort_ctrl_comp.sv | 28 ++
 rtl/comp_sort_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/comp_sort_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// comp_sort_ctrl_pkg
//
// Shared definitions for the batch sorter and its magnitude comparator:
//   - DATA_W : element width, fixed by the 4-bit comparator.
//   - CNT_W  : width of the compare counter (holds up to 8*7/2 = 28).
//   - state_e: sequencer states LOAD -> SORT -> DRAIN -> LOAD.
//   - clog2  : index width helper, never returns less than 1 so that a
//              two-element batch still gets a real index bit.
// -----------------------------------------------------------------------------
package comp_sort_ctrl_pkg;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage : comp_sort_ctrl_pkg

// File: rtl/comp_sort_ctrl_comp.sv
// -----------------------------------------------------------------------------
// comp
//
// Unsigned 4-bit magnitude comparator. Purely combinational; exactly one
// of the three flags is high for any pair of operands.
//
// Ports:
//   a_i  in  [DATA_W-1:0]  left operand
//   b_i  in  [DATA_W-1:0]  right operand
//   l_o  out               a_i is larger than b_i
//   e_o  out               a_i equals b_i
//   s_o  out               a_i is smaller than b_i
// -----------------------------------------------------------------------------
module comp
    import comp_sort_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              l_o,
    output logic              e_o,
    output logic              s_o
);

    assign l_o = (a_i >  b_i);
    assign e_o = (a_i == b_i);
    assign s_o = (a_i <  b_i);

endmodule : comp

// File: rtl/comp_sort_ctrl.sv
// -----------------------------------------------------------------------------
// comp_sort_ctrl
//
// Collects a batch of N 4-bit values over a valid/ready input stream, bubble
// sorts them in place using a single shared comparator (one compare per
// clock), then streams the sorted values out over a valid/ready output
// stream. Batches never overlap: input is accepted only in LOAD, output is
// offered only in DRAIN.
//
// Parameters:
//   N        elements per batch, 2..8
//   DESCEND  0 = smallest value first, 1 = largest value first
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous, active-high reset
//   in_valid   in   producer offers in_data
//   in_data    in   [3:0] value to load
//   in_ready   out  block accepts in_data this cycle (LOAD only)
//   out_valid  out  out_data holds a sorted value (DRAIN only)
//   out_data   out  [3:0] buffer entry selected by the read index
//   out_ready  in   consumer takes out_data this cycle
//   busy       out  high while sorting
//   cmp_cnt    out  [5:0] compares used by the most recent sort
// -----------------------------------------------------------------------------
module comp_sort_ctrl
    import comp_sort_ctrl_pkg::*;
#(
    parameter int N       = 4,
    parameter bit DESCEND = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  cmp_cnt
);

    localparam int IDX_W = clog2(N);

    // Index constants kept at index width so every compare is width-exact.
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(N - 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e              state_q,   state_d;
    logic [IDX_W-1:0]    wr_idx_q,  wr_idx_d;
    logic [IDX_W-1:0]    rd_idx_q,  rd_idx_d;
    logic [IDX_W-1:0]    pass_q,    pass_d;
    logic [IDX_W-1:0]    j_q,       j_d;
    logic                swapped_q, swapped_d;
    logic [CNT_W-1:0]    cmp_cnt_q, cmp_cnt_d;
    logic [DATA_W-1:0]   mem_q [N];
    logic [DATA_W-1:0]   mem_d [N];

    // -------------------------------------------------------------------------
    // Shared comparator: operands are buffer entries j and j+1
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0]  j_p1;
    logic [IDX_W-1:0]  last_j;
    logic [DATA_W-1:0] cmp_a;
    logic [DATA_W-1:0] cmp_b;
    logic              cmp_l;
    logic              cmp_e;
    logic              cmp_s;
    logic              out_of_order;

    assign j_p1   = j_q + IDX_ONE;
    // Each pass bubbles one more extreme value to the tail, so the last
    // compare position shrinks by one per pass.
    assign last_j = LAST_PASS - pass_q;
    assign cmp_a  = mem_q[j_q];
    assign cmp_b  = mem_q[j_p1];

    comp u_comp (
        .a_i (cmp_a),
        .b_i (cmp_b),
        .l_o (cmp_l),
        .e_o (cmp_e),
        .s_o (cmp_s)
    );

    // Equal operands never swap, which keeps the sort stable.
    assign out_of_order = ~cmp_e & (DESCEND ? cmp_s : cmp_l);

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    logic in_hs;
    logic out_hs;

    assign in_ready  = (state_q == LOAD)  & ~rst;
    assign out_valid = (state_q == DRAIN) & ~rst;
    assign busy      = (state_q == SORT)  & ~rst;
    assign out_data  = rst ? '0 : mem_q[rd_idx_q];
    assign cmp_cnt   = cmp_cnt_q;

    assign in_hs  = in_valid  & in_ready;
    assign out_hs = out_valid & out_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d is given its hold value first so no path leaves it
        // unassigned and no latch is inferred.
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        pass_d    = pass_q;
        j_d       = j_q;
        swapped_d = swapped_q;
        cmp_cnt_d = cmp_cnt_q;
        mem_d     = mem_q;

        unique case (state_q)
            LOAD: begin
                if (in_hs) begin
                    mem_d[wr_idx_q] = in_data;
                    if (wr_idx_q == LAST_IDX) begin
                        // Batch complete: start a fresh sort.
                        wr_idx_d  = '0;
                        state_d   = SORT;
                        cmp_cnt_d = '0;
                        pass_d    = '0;
                        j_d       = '0;
                        swapped_d = 1'b0;
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_ONE;
                    end
                end
            end

            SORT: begin
                cmp_cnt_d = cmp_cnt_q + CNT_ONE;
                if (out_of_order) begin
                    mem_d[j_q]  = mem_q[j_p1];
                    mem_d[j_p1] = mem_q[j_q];
                end
                if (j_q == last_j) begin
                    // A swap in this final compare still counts for the pass;
                    // otherwise a pass whose only swap is at the tail would
                    // end the sort early.
                    if (!(swapped_q | out_of_order) || (pass_q == LAST_PASS)) begin
                        state_d = DRAIN;
                    end else begin
                        pass_d    = pass_q + IDX_ONE;
                        j_d       = '0;
                        swapped_d = 1'b0;
                    end
                end else begin
                    j_d       = j_p1;
                    swapped_d = swapped_q | out_of_order;
                end
            end

            DRAIN: begin
                if (out_hs) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        state_d  = LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_ONE;
                    end
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values and the swap reads both old entries.
        if (rst) begin
            state_q   <= LOAD;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            pass_q    <= '0;
            j_q       <= '0;
            swapped_q <= 1'b0;
            cmp_cnt_q <= '0;
            // NOTE: the buffer is built from flops, so it is cleared on
            // reset like any other register and a discarded batch never
            // reappears on out_data.
            mem_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            pass_q    <= pass_d;
            j_q       <= j_d;
            swapped_q <= swapped_d;
            cmp_cnt_q <= cmp_cnt_d;
            mem_q     <= mem_d;
        end
    end

endmodule : comp_sort_ctrl
